alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, as listed below.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0_valid / req1_valid  input  1 each  port 0 / port 1 request present.
REQ-005 req0_ready / req1_ready  output  1 each  port 0 / port 1 request accepted this cycle.
REQ-006 req0_op / req1_op  input  3 each  ALU opcode: 000 ADD, 001 SUB, 010 XOR, 011 RED, 100 SLL, 101 SRA, 110 ROR, 111 PADDSB.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  16 each  operands.
REQ-008 alu_in1, alu_in2  output  16 each  operands driven to the shared combinational ALU.
REQ-009 alu_op  output  3  opcode driven to the ALU.
REQ-010 alu_out  input  16  ALU result, valid in the same cycle.
REQ-011 alu_flags  input  3  ALU flags, valid in the same cycle: bit2 Z, bit1 V, bit0 N.
REQ-012 rsp_valid  output  1  registered response present.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_data  output  16  registered result.
REQ-015 rsp_id  output  1  port that issued the response (0/1).
REQ-016 flags_q  output  3  architectural flag register {Z,V,N}.

Function
REQ-017 The block SHALL hold a one-entry output buffer, which is free when rsp_valid=0 or when rsp_valid=1 and rsp_ready=1 in the same cycle.
REQ-018 Accept SHALL occur when the buffer is free and at least one reqN_valid=1; exactly one reqN_ready SHALL be 1 (the granted port); both ready signals SHALL be 0 otherwise.
REQ-019 The grant SHALL be decided combinationally in the accept cycle; alu_in1/alu_in2/alu_op SHALL carry the granted port's a/b/op, or port 0's fields when no port is granted.
REQ-020 On accept, the block SHALL register rsp_data<=alu_out and rsp_id<=granted port, and set rsp_valid<=1; latency is 1 cycle and throughput is 1 per cycle with rsp_ready=1.
REQ-021 With rsp_valid=1 and rsp_ready=0, rsp_data and rsp_id SHALL remain stable and no request SHALL be accepted.
REQ-022 rsp_valid SHALL clear when rsp_ready=1 and there is no accept in the same cycle.
REQ-023 The flag register SHALL update only on accept, in the same clock edge: ADD/SUB load Z,V,N; XOR/SLL/SRA/ROR load Z only (V,N held); RED/PADDSB leave all flags unchanged.
REQ-024 Arbitration SHALL obey REQ-033/REQ-034, and a single valid requester SHALL always win when the buffer is free.
REQ-025 The grant state (last_grant) SHALL change only on accept.
REQ-026 A requester SHALL keep its fields stable while valid=1 and ready=0; the block SHALL not check this.

Reset
REQ-027 While rst_n=0, outputs SHALL be: rsp_valid=0, rsp_data=0x0000, rsp_id=0, flags_q=3'b000, last_grant=1 (port 0 favoured first), req0_ready=req1_ready=0.
REQ-028 Reset asserted mid-stall SHALL discard the buffered response; no response SHALL appear after deassertion until a new accept.
REQ-029 The first accept SHALL be possible in the first rising edge with rst_n=1.

Configuration
REQ-030 The macro ALU_ARBITER_RR_EN SHALL select the arbitration policy.
REQ-031 With ALU_ARBITER_RR_EN defined, the policy SHALL be round-robin (REQ-033).
REQ-032 Without ALU_ARBITER_RR_EN, the policy SHALL be fixed priority (REQ-034); last_grant is then unused, and the ports and all other behaviour are identical.
REQ-033 Round-robin: when both requesters are valid, the block SHALL grant the port not equal to last_grant.
REQ-034 Fixed priority: port 0 SHALL always win over port 1.

Verification
REQ-035 Scenario: port0 ADD a=0x7FFF b=0x0001 -> next cycle rsp_valid=1, rsp_data=0x8000, rsp_id=0, flags_q=3'b011.
REQ-036 Scenario: after REQ-035, port1 XOR a=0x00FF b=0x00FF -> rsp_data=0x0000, rsp_id=1, flags_q=3'b111 (Z loaded, V,N held); then RED -> flags_q unchanged.
REQ-037 Scenario: both valid for 4 consecutive cycles, rsp_ready=1 -> grants 0,1,0,1 with the macro; 0,0,0,0 without it.
REQ-038 Scenario: rsp_ready=0 for 3 cycles with both valid -> rsp_data/rsp_id stable, req0_ready=req1_ready=0; on rsp_ready=1 the next request is accepted that same cycle.
REQ-039 Scenario: rst_n pulsed low during the REQ-038 stall -> rsp_valid=0 and flags_q=3'b000 immediately; after release, port 0 wins first.
REQ-040 Scenario: port0 SUB a=0x0005 b=0x0005 -> rsp_data=0x0000, flags_q=3'b100.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port arbiter in front of a shared combinational ALU,
// with a one-entry registered response buffer and a {Z,V,N} flag register.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   reqN_valid/ready/op/a/b       request ports 0 and 1
//   alu_in1, alu_in2, alu_op      operands/opcode to the external ALU
//   alu_out, alu_flags            same-cycle ALU result and {Z,V,N}
//   rsp_valid/ready/data/id       registered response channel
//   flags_q                       architectural flags {Z,V,N}
//
// Config: define ALU_ARBITER_RR_EN for round-robin arbitration;
// otherwise port 0 has fixed priority over port 1.

module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_out,
  input  logic [2:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_id,
  output logic [2:0]  flags_q
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;
  localparam logic [2:0] OP_ROR = 3'b110;

  logic        r_rsp_valid;
  logic [15:0] r_rsp_data;
  logic        r_rsp_id;
  logic [2:0]  r_flags;

  logic w_free;
  logic w_any;
  logic w_gnt1;
  logic w_accept;
  logic w_sel1;

  // Buffer drains and refills in the same cycle when the consumer takes it.
  assign w_free = ~r_rsp_valid | rsp_ready;
  assign w_any  = req0_valid | req1_valid;

`ifdef ALU_ARBITER_RR_EN
  logic r_last_grant;

  // Port 1 wins if alone, or if both want it and port 0 went last.
  assign w_gnt1 = req1_valid &
                  (~req0_valid | ~r_last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_gnt1;
    end
  end
`else
  assign w_gnt1 = req1_valid & ~req0_valid;
`endif

  // rst_n gates the readies so nothing is granted while held in reset.
  assign w_accept   = rst_n & w_free & w_any;
  assign w_sel1     = w_accept & w_gnt1;
  assign req0_ready = w_accept & ~w_gnt1;
  assign req1_ready = w_sel1;

  assign alu_in1 = w_sel1 ? req1_a  : req0_a;
  assign alu_in2 = w_sel1 ? req1_b  : req0_b;
  assign alu_op  = w_sel1 ? req1_op : req0_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 16'h0000;
      r_rsp_id    <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= alu_out;
      r_rsp_id    <= w_gnt1;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Arithmetic ops own all flags, logic/shift ops only Z,
  // RED and PADDSB leave the flags alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 3'b000;
    end else if (w_accept) begin
      unique case (alu_op)
        OP_ADD, OP_SUB: r_flags <= alu_flags;
        OP_XOR, OP_SLL,
        OP_SRA, OP_ROR: r_flags[2] <= alu_flags[2];
        default: r_flags <= r_flags;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign flags_q   = r_flags;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a behavioural ALU.
// Works with or without ALU_ARBITER_RR_EN defined.

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [15:0] alu_in1, alu_in2;
  logic [2:0]  alu_op;
  logic [15:0] alu_out;
  logic [2:0]  alu_flags;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_id;
  logic [2:0]  flags_q;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
    .flags_q(flags_q)
  );

  // External shared ALU: result and {Z,V,N} in the same cycle.
  logic [15:0] r;
  logic        v;
  always_comb begin
    r = 16'h0000;
    v = 1'b0;
    case (alu_op)
      3'b000: begin
        r = alu_in1 + alu_in2;
        v = (alu_in1[15] == alu_in2[15]) && (r[15] != alu_in1[15]);
      end
      3'b001: begin
        r = alu_in1 - alu_in2;
        v = (alu_in1[15] != alu_in2[15]) && (r[15] != alu_in1[15]);
      end
      3'b010: r = alu_in1 ^ alu_in2;
      3'b011: r = {15'b0, ^alu_in1};
      3'b100: r = alu_in1 << alu_in2[3:0];
      3'b101: r = $signed(alu_in1) >>> alu_in2[3:0];
      3'b110: r = (alu_in1 >> alu_in2[3:0]) |
                  (alu_in1 << (5'd16 - {1'b0, alu_in2[3:0]}));
      default: begin
        r[15:8] = alu_in1[15:8] + alu_in2[15:8];
        r[7:0]  = alu_in1[7:0] + alu_in2[7:0];
      end
    endcase
    alu_out   = r;
    alu_flags = {(r == 16'h0000), v, r[15]};
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v0, input logic [2:0] o0,
                     input logic [15:0] a0, input logic [15:0] b0,
                     input logic v1, input logic [2:0] o1,
                     input logic [15:0] a1, input logic [15:0] b1);
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_flags", flags_q, 0);
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic e1;
  logic [15:0] ed;
  logic [2:0]  ef;

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    drv(1, 3'b000, 16'h1234, 16'h1, 1, 3'b000, 16'h1, 16'h1);
    #12;
    chk("rst_valid0", rsp_valid, 0);
    chk("rst_data0", rsp_data, 16'h0000);
    chk("rst_id0", rsp_id, 0);
    chk("rst_flags0", flags_q, 0);
    chk("rst_rdy0_0", req0_ready, 0);
    chk("rst_rdy1_0", req1_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drv(0, 3'b000, 0, 0, 0, 3'b000, 0, 0);
    cyc();
    chk("idle_valid", rsp_valid, 0);

    // Port 0 ADD overflow
    drv(1, 3'b000, 16'h7FFF, 16'h0001, 0, 3'b000, 0, 0);
    chk("add_rdy0", req0_ready, 1);
    chk("add_in1", alu_in1, 16'h7FFF);
    cyc();
    chk("add_valid", rsp_valid, 1);
    chk("add_data", rsp_data, 16'h8000);
    chk("add_id", rsp_id, 0);
    chk("add_flags", flags_q, 3'b011);

    // Port 1 XOR -> zero, only Z loads
    drv(0, 3'b000, 0, 0, 1, 3'b010, 16'h00FF, 16'h00FF);
    chk("xor_rdy1", req1_ready, 1);
    chk("xor_op", alu_op, 3'b010);
    cyc();
    chk("xor_data", rsp_data, 16'h0000);
    chk("xor_id", rsp_id, 1);
    chk("xor_flags", flags_q, 3'b111);

    // RED leaves flags
    drv(0, 3'b000, 0, 0, 1, 3'b011, 16'h0007, 16'h0000);
    cyc();
    chk("red_data", rsp_data, 16'h0001);
    chk("red_flags", flags_q, 3'b111);

    // SUB to zero
    drv(1, 3'b001, 16'h0005, 16'h0005, 0, 3'b000, 0, 0);
    cyc();
    chk("sub_data", rsp_data, 16'h0000);
    chk("sub_id", rsp_id, 0);
    chk("sub_flags", flags_q, 3'b100);

    // Drain with no new request
    drv(0, 3'b000, 0, 0, 0, 3'b000, 0, 0);
    cyc();
    chk("drain_valid", rsp_valid, 0);

    // Arbitration from a fresh reset, both valid
    do_reset();
    drv(1, 3'b000, 16'h7FFF, 16'h0001, 1, 3'b000, 16'h0003, 16'h0004);
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARBITER_RR_EN
      e1 = i[0];
`else
      e1 = 1'b0;
`endif
      ed = e1 ? 16'h0007 : 16'h8000;
      ef = e1 ? 3'b000 : 3'b011;
      chk("arb_rdy0", req0_ready, !e1);
      chk("arb_rdy1", req1_ready, e1);
      cyc();
      chk("arb_id", rsp_id, e1);
      chk("arb_data", rsp_data, ed);
      chk("arb_flags", flags_q, ef);
    end

    // Stall: nothing accepted, response held
    rsp_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stl_rdy0", req0_ready, 0);
      chk("stl_rdy1", req1_ready, 0);
      cyc();
      chk("stl_valid", rsp_valid, 1);
      chk("stl_id", rsp_id, e1);
      chk("stl_data", rsp_data, ed);
    end
    rsp_ready = 1'b1;
    #1;
    chk("rel_rdy0", req0_ready, 1);
    chk("rel_rdy1", req1_ready, 0);
    cyc();
    chk("rel_id", rsp_id, 0);
    chk("rel_data", rsp_data, 16'h8000);
    chk("rel_flags", flags_q, 3'b011);

    // Reset in the middle of a stall
    rsp_ready = 1'b0;
    cyc();
    chk("pre_valid", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", rsp_valid, 0);
    chk("mid_flags", flags_q, 3'b000);
    chk("mid_data", rsp_data, 16'h0000);
    chk("mid_rdy0", req0_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    drv(0, 3'b000, 0, 0, 0, 3'b000, 0, 0);
    cyc();
    chk("post_valid", rsp_valid, 0);
    drv(1, 3'b000, 16'h0001, 16'h0001, 1, 3'b000, 16'h0003, 16'h0004);
    chk("post_rdy0", req0_ready, 1);
    chk("post_rdy1", req1_ready, 0);
    cyc();
    chk("post_id", rsp_id, 0);
    chk("post_data", rsp_data, 16'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
